// File: rtl/ryu_punch_sequencer_if.sv
// ryu_punch_sequencer_if: scan/ROM/palette signals shared by the punch sequencer and its driver
interface ryu_punch_sequencer_if #(parameter int ROM_AW = 15);
  logic              vsync_tick;
  logic              punch_req;
  logic              facing_left;
  logic [9:0]        ryu_x;
  logic [9:0]        ryu_y;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ROM_AW-1:0] rom_addr;
  logic [3:0]        rom_index;
  logic [3:0]        pal_index;
  logic              pixel_valid;
  logic              busy;
  logic [1:0]        frame_num;
  modport master (
    output vsync_tick, punch_req, facing_left, ryu_x, ryu_y, DrawX, DrawY, rom_index,
    input  rom_addr, pal_index, pixel_valid, busy, frame_num
  );
  modport slave (
    input  vsync_tick, punch_req, facing_left, ryu_x, ryu_y, DrawX, DrawY, rom_index,
    output rom_addr, pal_index, pixel_valid, busy, frame_num
  );
endinterface

// File: rtl/ryu_punch_sequencer.sv
// ryu_punch_sequencer: punch animation FSM stepped on vsync plus a 3-cycle sprite pixel fetch pipeline
module ryu_punch_sequencer #(
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 96,
  parameter int NUM_FRAMES      = 3,
  parameter int TICKS_PER_FRAME = 4,
  parameter int COOLDOWN_TICKS  = 6,
  parameter int ROM_AW          = 15
) (
  input logic Clk,
  input logic Reset,
  ryu_punch_sequencer_if.slave bus
);
  localparam int CMAX = TICKS_PER_FRAME > COOLDOWN_TICKS ? TICKS_PER_FRAME : COOLDOWN_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, PUNCH, COOLDOWN} state_t;
  state_t          state, state_n;
  logic [1:0]      frame, frame_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic            pending, pending_n;
  logic [10:0]     dx, dy, col;
  logic            inbox, inbox_d1, inbox_d2;
  logic [ROM_AW-1:0] addr_n;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      frame   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      frame   <= frame_n;
      cnt     <= cnt_n;
      pending <= pending_n;
    end
  end
  assign cnt_inc = cnt + 1'b1;
  always_comb begin
    state_n   = state;
    frame_n   = frame;
    cnt_n     = cnt;
    pending_n = pending;
    case (state)
      IDLE: begin
        pending_n = pending | bus.punch_req;
        if (bus.vsync_tick && (pending | bus.punch_req)) begin
          state_n   = PUNCH;
          frame_n   = '0;
          cnt_n     = '0;
          pending_n = 1'b0;
        end
      end
      PUNCH: if (bus.vsync_tick) begin
        cnt_n = cnt_inc == CW'(TICKS_PER_FRAME) ? '0 : cnt_inc;
        if (cnt_inc == CW'(TICKS_PER_FRAME)) begin
          state_n = frame == 2'(NUM_FRAMES - 1) ? COOLDOWN : PUNCH;
          frame_n = frame == 2'(NUM_FRAMES - 1) ? 2'd0 : frame + 2'd1;
        end
      end
      COOLDOWN: if (bus.vsync_tick) begin
        state_n = cnt_inc == CW'(COOLDOWN_TICKS) ? IDLE : COOLDOWN;
        cnt_n   = cnt_inc == CW'(COOLDOWN_TICKS) ? '0 : cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.busy      = state != IDLE;
  assign bus.frame_num = frame;
  // dx/dy are 11-bit two's complement so scan positions left of / above the sprite fail the box test
  assign dx     = {1'b0, bus.DrawX} - {1'b0, bus.ryu_x};
  assign dy     = {1'b0, bus.DrawY} - {1'b0, bus.ryu_y};
  assign inbox  = !dx[10] && dx < 11'(SPRITE_W) && !dy[10] && dy < 11'(SPRITE_H);
  assign col    = bus.facing_left ? 11'(SPRITE_W - 1) - dx : dx;
  assign addr_n = ROM_AW'(frame) * ROM_AW'(SPRITE_W * SPRITE_H) + ROM_AW'(dy) * ROM_AW'(SPRITE_W) + ROM_AW'(col);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.rom_addr    <= '0;
      inbox_d1        <= 1'b0;
      inbox_d2        <= 1'b0;
      bus.pal_index   <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      bus.rom_addr    <= inbox ? addr_n : '0;
      inbox_d1        <= inbox;
      inbox_d2        <= inbox_d1;
      bus.pal_index   <= bus.rom_index;
      bus.pixel_valid <= inbox_d2 && (bus.rom_index != 4'd0);
    end
  end
endmodule

// File: tb/tb_ryu_punch_sequencer.sv
// tb_ryu_punch_sequencer: directed checks of punch animation timing and sprite pixel pipeline
module tb_ryu_punch_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  ryu_punch_sequencer_if bus();
  ryu_punch_sequencer dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic tick();
    bus.vsync_tick = 1'b1;
    cyc(1);
    bus.vsync_tick = 1'b0;
  endtask
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic fl);
    bus.DrawX = x;
    bus.DrawY = y;
    bus.facing_left = fl;
  endtask
  initial begin
    bus.vsync_tick = 1'b0;
    bus.punch_req = 1'b0;
    bus.rom_index = 4'd0;
    bus.ryu_x = 10'd100;
    bus.ryu_y = 10'd200;
    pix(10'd0, 10'd0, 1'b0);
    #12;
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_pal", 32'(bus.pal_index), 0);
    chk("rst_pv", 32'(bus.pixel_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_frame", 32'(bus.frame_num), 0);
    cyc(1);
    Reset = 1'b0;
    pix(10'd100, 10'd200, 1'b0); cyc(1); chk("addr_origin", 32'(bus.rom_addr), 0);
    pix(10'd101, 10'd201, 1'b0); cyc(1); chk("addr_1_1", 32'(bus.rom_addr), 65);
    pix(10'd100, 10'd200, 1'b1); cyc(1); chk("addr_mirror", 32'(bus.rom_addr), 63);
    pix(10'd101, 10'd201, 1'b1); cyc(1); chk("addr_mirror_1_1", 32'(bus.rom_addr), 126);
    pix(10'd100, 10'd199, 1'b0); cyc(1); chk("addr_above", 32'(bus.rom_addr), 0);
    pix(10'd100, 10'd200, 1'b0);
    bus.rom_index = 4'd8;
    cyc(3);
    chk("pal_in", 32'(bus.pal_index), 8);
    chk("pv_in", 32'(bus.pixel_valid), 1);
    pix(10'd99, 10'd200, 1'b0);
    cyc(1); chk("addr_left", 32'(bus.rom_addr), 0);
    cyc(1); chk("pv_left_n2", 32'(bus.pixel_valid), 1);
    cyc(1); chk("pv_left_n3", 32'(bus.pixel_valid), 0);
    chk("pal_left", 32'(bus.pal_index), 8);
    pix(10'd100, 10'd200, 1'b0);
    bus.rom_index = 4'd0;
    cyc(3);
    chk("pv_transparent", 32'(bus.pixel_valid), 0);
    chk("pal_transparent", 32'(bus.pal_index), 0);
    bus.punch_req = 1'b1;
    cyc(1);
    bus.punch_req = 1'b0;
    cyc(2);
    chk("pending_no_tick_busy", 32'(bus.busy), 0);
    tick();
    chk("T0_busy", 32'(bus.busy), 1);
    chk("T0_frame", 32'(bus.frame_num), 0);
    for (int t = 1; t <= 21; t++) begin
      cyc(2);
      if (t == 5 || t == 14) begin
        bus.punch_req = 1'b1;
        cyc(1);
      end
      tick();
      bus.punch_req = 1'b0;
      chk($sformatf("T%0d_frame", t), 32'(bus.frame_num), t < 4 ? 0 : t < 8 ? 1 : t < 12 ? 2 : 0);
      chk($sformatf("T%0d_busy", t), 32'(bus.busy), t < 18 ? 1 : 0);
    end
    bus.rom_index = 4'd8;
    bus.punch_req = 1'b1;
    tick();
    bus.punch_req = 1'b0;
    chk("same_tick_busy", 32'(bus.busy), 1);
    chk("same_tick_frame", 32'(bus.frame_num), 0);
    repeat (4) tick();
    chk("mid_frame", 32'(bus.frame_num), 1);
    chk("mid_pv", 32'(bus.pixel_valid), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_busy", 32'(bus.busy), 0);
    chk("async_frame", 32'(bus.frame_num), 0);
    chk("async_pv", 32'(bus.pixel_valid), 0);
    #2 Reset = 1'b0;
    bus.punch_req = 1'b1;
    tick();
    bus.punch_req = 1'b0;
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_frame", 32'(bus.frame_num), 0);
    repeat (8) tick();
    chk("f2_frame", 32'(bus.frame_num), 2);
    pix(10'd163, 10'd295, 1'b0);
    cyc(1); chk("f2_addr_corner", 32'(bus.rom_addr), 18431);
    cyc(2); chk("f2_pv_corner", 32'(bus.pixel_valid), 1);
    pix(10'd164, 10'd295, 1'b0);
    cyc(1); chk("f2_addr_right", 32'(bus.rom_addr), 0);
    cyc(2); chk("f2_pv_right", 32'(bus.pixel_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
